// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data memory responder with byte/half/word access
// Optional build macro: DMEM_MISALIGN_TRAP_EN (flag misaligned H/W accesses instead of aligning down)
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req_valid,
    input  logic        i_mem_rw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_load_store_mode,
    output logic        o_mem_rdy,
    output logic        o_resp_valid,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        rw_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mode_q;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;
    logic [AW-1:0] rd_idx;
    logic        accept;

    logic [3:0]  be;
    logic [3:0]  wr_be;
    logic [31:0] wdata_sh;
    logic [31:0] load_val;
    logic        misal;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[31:AW+2];

    assign accept = i_req_valid && (state == ST_IDLE);
    // Read port tracks the incoming address on accept so data is ready even with zero wait states
    assign rd_idx = accept ? i_addr[AW+1:2] : addr_q[AW+1:2];

    assign byte_sel = 8'(rd_word >> {addr_q[1:0], 3'b000});
    assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        be       = 4'b0000;
        wdata_sh = 32'h0;
        load_val = 32'h0;
        misal    = 1'b0;
        case (mode_q)
            3'b000, 3'b100: begin
                be       = 4'b0001 << addr_q[1:0];
                wdata_sh = {24'h0, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
                load_val = mode_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            3'b001, 3'b101: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misal    = addr_q[0];
`endif
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_sh = addr_q[1] ? {wdata_q[15:0], 16'h0} : {16'h0, wdata_q[15:0]};
                load_val = mode_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            3'b010: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                misal    = |addr_q[1:0];
`endif
                be       = 4'b1111;
                wdata_sh = wdata_q;
                load_val = rd_word;
            end
            default: begin
                be       = 4'b0000;
                load_val = 32'h0;
            end
        endcase
        if (misal) begin
            be       = 4'b0000;
            load_val = 32'h0;
        end
    end

    // A reset landing on the RESP edge must not commit the store
    assign wr_be = (rw_q && state == ST_RESP && !reset) ? be : 4'b0000;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
        rd_word <= mem[rd_idx];
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign_q;
    assign o_misalign = misalign_q;
`else
    assign o_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            mode_q       <= 3'b000;
            o_mem_rdy    <= 1'b0;
            o_resp_valid <= 1'b0;
            o_rdata      <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            o_resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    o_mem_rdy <= 1'b1;
                    if (i_req_valid) begin
                        rw_q      <= i_mem_rw;
                        addr_q    <= i_addr[AW+1:0];
                        wdata_q   <= i_wdata;
                        mode_q    <= i_load_store_mode;
                        o_mem_rdy <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                            cnt   <= 4'd0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    o_mem_rdy    <= 1'b1;
                    o_resp_valid <= 1'b1;
                    o_rdata      <= rw_q ? 32'h0 : load_val;
`ifdef DMEM_MISALIGN_TRAP_EN
                    misalign_q   <= misal;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        i_mem_rw;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_load_store_mode;
    logic        o_mem_rdy;
    logic        o_resp_valid;
    logic [31:0] o_rdata;
    logic        o_misalign;

    localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010, M_BU = 3'b100, M_HU = 3'b101;

    int checks = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .i_req_valid(i_req_valid),
        .i_mem_rw(i_mem_rw),
        .i_addr(i_addr),
        .i_wdata(i_wdata),
        .i_load_store_mode(i_load_store_mode),
        .o_mem_rdy(o_mem_rdy),
        .o_resp_valid(o_resp_valid),
        .o_rdata(o_rdata),
        .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] mode, output logic [31:0] rdata,
                          output logic mis, output int lat);
        @(negedge clk);
        i_mem_rw = rw; i_addr = addr; i_wdata = wdata; i_load_store_mode = mode;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        lat = 0; rdata = 32'h0; mis = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (o_resp_valid) begin
                lat = k; rdata = o_rdata; mis = o_misalign;
                break;
            end
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [2:0] mode);
        logic [31:0] rd; logic mis; int lat;
        do_req(1'b1, addr, data, mode, rd, mis, lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_rdata0"}, rd, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [2:0] mode,
                      input logic [31:0] exp, input logic exp_mis);
        logic [31:0] r; logic mis; int lat;
        do_req(1'b0, addr, 32'h0, mode, r, mis, lat);
        check({tag, "_lat"}, lat, 3);
        check(tag, r, exp);
        check({tag, "_mis"}, {31'h0, mis}, {31'h0, exp_mis});
    endtask

    initial begin
        logic [7:0] rdy_v, rv_v;
        logic seen;
        reset = 1'b1; i_req_valid = 1'b0; i_mem_rw = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_load_store_mode = M_W;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'h0, o_mem_rdy}, 32'h0);
        check("rst_rv", {31'h0, o_resp_valid}, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_mis", {31'h0, o_misalign}, 32'h0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("rel_rdy", {31'h0, o_mem_rdy}, 32'h1);

        wr("sw_dead", 32'h100, 32'hDEADBEEF, M_W);
        rd("lw_dead", 32'h100, M_W, 32'hDEADBEEF, 1'b0);
        repeat (3) @(posedge clk);
        #1 check("rdata_hold", o_rdata, 32'hDEADBEEF);

        wr("sw_1122", 32'h100, 32'h11223344, M_W);
        wr("sb_a5", 32'h101, 32'h000000A5, M_B);
        rd("lw_merge", 32'h100, M_W, 32'h1122A544, 1'b0);
        rd("lb_101", 32'h101, M_B, 32'hFFFFFFA5, 1'b0);
        rd("lbu_101", 32'h101, M_BU, 32'h000000A5, 1'b0);

        wr("sw_8001", 32'h200, 32'h80010000, M_W);
        rd("lh_202", 32'h202, M_H, 32'hFFFF8001, 1'b0);
        rd("lhu_202", 32'h202, M_HU, 32'h00008001, 1'b0);
        rd("lh_200", 32'h200, M_H, 32'h00000000, 1'b0);
        rd("lb_203", 32'h203, M_B, 32'hFFFFFF80, 1'b0);

        wr("sw_wrap", 32'h1000, 32'h12345678, M_W);
        rd("lw_wrap", 32'h0, M_W, 32'h12345678, 1'b0);
        wr("sh_2", 32'h2, 32'h0000BEEF, M_H);
        rd("lw_sh", 32'h0, M_W, 32'hBEEF5678, 1'b0);

        // Request held high across two loads
        @(negedge clk);
        i_mem_rw = 1'b0; i_addr = 32'h100; i_load_store_mode = M_W; i_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            rdy_v[k] = o_mem_rdy;
            rv_v[k] = o_resp_valid;
        end
        i_req_valid = 1'b0;
        check("held_rdy", {24'h0, rdy_v}, 32'h88);
        check("held_rv", {24'h0, rv_v}, 32'h88);
        check("held_rdata", o_rdata, 32'h1122A544);

        // Reset during WAIT aborts the store
        wr("sw_40", 32'h40, 32'h0BADCAFE, M_W);
        @(negedge clk);
        i_mem_rw = 1'b1; i_addr = 32'h40; i_wdata = 32'hCAFEF00D; i_load_store_mode = M_W;
        i_req_valid = 1'b1;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1 seen |= o_resp_valid;
        end
        check("abort_rdy", {31'h0, o_mem_rdy}, 32'h0);
        @(negedge clk) reset = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1 seen |= o_resp_valid;
        end
        check("abort_pulse", {31'h0, seen}, 32'h0);
        rd("lw_40", 32'h40, M_W, 32'h0BADCAFE, 1'b0);

        wr("sw_5566", 32'h100, 32'h55667788, M_W);
`ifdef DMEM_MISALIGN_TRAP_EN
        rd("lw_102", 32'h102, M_W, 32'h00000000, 1'b1);
`else
        rd("lw_102", 32'h102, M_W, 32'h55667788, 1'b0);
`endif
        wr("rsv_st", 32'h100, 32'hFFFFFFFF, 3'b011);
        rd("lw_rsv", 32'h100, M_W, 32'h55667788, 1'b0);
        rd("rsv_ld", 32'h100, 3'b110, 32'h00000000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request accept and response; range 0..15.
REQ-003 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port reset  input  1  reset, synchronous and active-high.
REQ-005 Port i_req_valid  input  1  request present.
REQ-006 Port i_mem_rw  input  1  1 = store, 0 = load.
REQ-007 Port i_addr  input  32  byte address.
REQ-008 Port i_wdata  input  32  store data, right-aligned.
REQ-009 Port i_load_store_mode  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Port o_mem_rdy  output  1  high only in IDLE; drives the core's MEM_RDY.
REQ-011 Port o_resp_valid  output  1  one-cycle response pulse.
REQ-012 Port o_rdata  output  32  load result, extended per mode.
REQ-013 Port o_misalign  output  1  misaligned-access flag, qualified by o_resp_valid.

Function
REQ-014 States IDLE, WAIT, RESP; request accepted on the edge where i_req_valid=1 and state=IDLE.
REQ-015 On accept, addr/wdata/mode/rw latch; go WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-016 WAIT counter loads WAIT_CYCLES-1 on accept, decrements each cycle, moves to RESP after reaching 0; RESP lasts exactly one cycle, then IDLE.
REQ-017 Latency: accept at edge N gives o_resp_valid=1 in the cycle after edge N+WAIT_CYCLES+1; o_mem_rdy is low for exactly WAIT_CYCLES+1 cycles per transaction.
REQ-018 Inputs outside IDLE are ignored; a request held through busy is accepted at the first IDLE edge.
REQ-019 Word index = latched addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-020 Store commits on the RESP edge via byte-enable: B writes lane addr[1:0], H writes lanes {addr[1],x}, W all four; other lanes unchanged.
REQ-021 Load: B/H sign-extend, BU/HU zero-extend, lane chosen by addr[1:0] / addr[1]; o_rdata held until next response, 0 for stores.
REQ-022 Reserved modes (011, 110, 111): no write, o_rdata=0, response still issued.
REQ-023 Storage read synchronously (block-RAM inferable); contents are not initialised by reset.

Reset
REQ-024 Reset forces IDLE, counter 0, o_resp_valid=0, o_rdata=0, o_misalign=0, o_mem_rdy=0 during reset, 1 in the first cycle after release.
REQ-025 Reset mid-transaction aborts it: no store commit, no response pulse.

Configuration
REQ-026 Macro DMEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 suppresses the store, returns o_rdata=0, asserts o_misalign=1 with o_resp_valid.
REQ-027 Macro undefined: misaligned addresses align down (H ignores addr[0], W ignores addr[1:0]); o_misalign tied 0.

Verification
REQ-028 SW 0xDEADBEEF @0x100 then LW @0x100 -> o_rdata=0xDEADBEEF, o_resp_valid exactly 3 cycles after accept (WAIT_CYCLES=2).
REQ-029 Word 0x11223344 @0x100, SB 0x000000A5 @0x101 -> LW 0x1122A544, LB @0x101 0xFFFFFFA5, LBU 0x000000A5.
REQ-030 Word 0x80010000 @0x200: LH @0x202 -> 0xFFFF8001, LHU @0x202 -> 0x00008001; SW @0x1000 (DEPTH 1024) then LW @0x0 -> same data.
REQ-031 i_req_valid held high across two loads -> second accepted only after RESP; o_mem_rdy low 3 cycles per transaction.
REQ-032 Reset asserted in WAIT of SW 0xCAFEF00D @0x40 -> no response pulse; subsequent LW @0x40 returns prior value.
REQ-033 LW @0x102 over word 0x55667788 @0x100: with DMEM_MISALIGN_TRAP_EN -> o_misalign=1, o_rdata=0; without -> o_rdata=0x55667788, o_misalign=0.
